// File: rtl/zigbee_tx_pkg.sv
// zigbee_tx_pkg: framer states and frame constants shared by the transmitter files
package zigbee_tx_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, LENGTH, PAYLOAD} state_t;
  localparam int PREAMBLE_BITS = 32;
  localparam logic [7:0] SFD_BYTE = 8'hA7;
  localparam int MAX_LEN = 127;
  localparam int NIB_BUF_DEPTH = 2;
endpackage

// File: rtl/tx_nibble_buf.sv
// tx_nibble_buf: two-entry nibble fifo between host and serialiser, push and pop may coincide
module tx_nibble_buf
  import zigbee_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [3:0] din,
  input  logic       pop,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty
);
  logic [3:0] mem_q [NIB_BUF_DEPTH];
  logic [3:0] mem_d [NIB_BUF_DEPTH];
  logic wr_q, wr_d, rd_q, rd_d, do_push, do_pop;
  logic [1:0] cnt_q, cnt_d;
  assign full = cnt_q == 2'(NIB_BUF_DEPTH);
  assign empty = cnt_q == 2'd0;
  assign dout = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  always_comb begin
    mem_d = mem_q;
    mem_d[wr_q] = do_push ? din : mem_q[wr_q];
    wr_d = wr_q ^ do_push;
    rd_d = rd_q ^ do_pop;
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/tx_framer.sv
// tx_framer: serialises preamble, sfd, length and buffered host nibbles lsb first to a bit modulator
module tx_framer
  import zigbee_tx_pkg::*;
(
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inStart,
  input  logic [6:0] inLength,
  input  logic [3:0] inData,
  input  logic       inValid,
  output logic       outReady,
  input  logic       inBitReq,
  output logic       outBit,
  output logic       outEmpty,
  output logic       outBusy,
  output logic       outDone,
  output logic       outError
);
  state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] pre_cnt_q, pre_cnt_d;
  logic [6:0] len_q, len_d;
  logic [7:0] acc_q, acc_d, len_byte;
  logic [3:0] cur_q, cur_d, buf_dout;
  logic cur_valid_q, cur_valid_d, done_q, done_d, err_q, err_d;
  logic push, pop, load, take, buf_full, buf_empty;
  tx_nibble_buf u_buf (
    .clk(inClock),
    .rst(inReset),
    .push(push),
    .din(inData),
    .pop(pop),
    .dout(buf_dout),
    .full(buf_full),
    .empty(buf_empty)
  );
  assign len_byte = {1'b0, len_q};
  assign outBusy = state_q != IDLE;
  assign outEmpty = state_q == IDLE || (state_q == PAYLOAD && !cur_valid_q);
  assign outBit = state_q == SFD ? SFD_BYTE[bit_cnt_q] :
                  state_q == LENGTH ? len_byte[bit_cnt_q] :
                  state_q == PAYLOAD ? cur_valid_q & cur_q[bit_cnt_q[1:0]] : 1'b0;
  assign outReady = outBusy && !buf_full && acc_q < {len_q, 1'b0};
  assign outDone = done_q;
  assign outError = err_q;
  assign push = inValid & outReady;
  assign take = inBitReq & ~outEmpty;
  assign pop = load & ~buf_empty;
  always_comb begin
    state_d = state_q;
    bit_cnt_d = take ? bit_cnt_q + 3'd1 : bit_cnt_q;
    pre_cnt_d = pre_cnt_q;
    len_d = len_q;
    acc_d = acc_q + 8'(push);
    cur_d = cur_q;
    cur_valid_d = cur_valid_q;
    done_d = 1'b0;
    err_d = err_q;
    load = 1'b0;
    case (state_q)
      IDLE: if (inStart) begin
        err_d = inLength == 7'd0;
        if (inLength != 7'd0) begin
          state_d = PREAMBLE;
          len_d = inLength;
          acc_d = 8'd0;
          bit_cnt_d = 3'd0;
          pre_cnt_d = 2'd0;
        end
      end
      PREAMBLE: if (take && bit_cnt_q == 3'd7) begin
        pre_cnt_d = pre_cnt_q + 2'd1;
        state_d = {pre_cnt_q, bit_cnt_q} == 5'(PREAMBLE_BITS - 1) ? SFD : PREAMBLE;
      end
      SFD: state_d = take && bit_cnt_q == 3'd7 ? LENGTH : SFD;
      LENGTH: if (take && bit_cnt_q == 3'd7) begin
        state_d = PAYLOAD;
        load = 1'b1;
      end
      PAYLOAD: if (take && bit_cnt_q[1:0] == 2'd3) begin
        if (acc_q == {len_q, 1'b0} && buf_empty) begin
          state_d = IDLE;
          done_d = 1'b1;
          cur_valid_d = 1'b0;
          bit_cnt_d = 3'd0;
        end else load = 1'b1;
      end else load = !cur_valid_q;
      default: state_d = IDLE;
    endcase
    if (load) begin
      cur_d = buf_dout;
      cur_valid_d = !buf_empty;
      bit_cnt_d = 3'd0;
    end
    err_d = err_d | (state_d == PAYLOAD && !cur_valid_d);
  end
  always_ff @(posedge inClock or posedge inReset)
    if (inReset) begin
      state_q <= IDLE;
      bit_cnt_q <= 3'd0;
      pre_cnt_q <= 2'd0;
      len_q <= 7'd0;
      acc_q <= 8'd0;
      cur_q <= 4'd0;
      cur_valid_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      len_q <= len_d;
      acc_q <= acc_d;
      cur_q <= cur_d;
      cur_valid_q <= cur_valid_d;
      done_q <= done_d;
      err_q <= err_d;
    end
endmodule

// File: tb/tb_tx_framer.sv
// tb_tx_framer: directed and randomized frames checked against a bitstream model of the frame format
module tb_tx_framer;
  logic inClock = 1'b0, inReset = 1'b0, inStart = 1'b0, inValid = 1'b0, inBitReq = 1'b0;
  logic [6:0] inLength = '0;
  logic [3:0] inData = '0;
  logic outReady, outBit, outEmpty, outBusy, outDone, outError;
  int n_chk = 0, n_fail = 0, cyc = 0, period = 1, done_cnt = 0, done_at = -1;
  bit rnd_valid = 1'b0, err_seen = 1'b0, done_empty = 1'b0;
  bit got[$], exp_bits[$];
  logic [3:0] host_q[$], nibs[$];
  tx_framer dut (
    .inClock(inClock),
    .inReset(inReset),
    .inStart(inStart),
    .inLength(inLength),
    .inData(inData),
    .inValid(inValid),
    .outReady(outReady),
    .inBitReq(inBitReq),
    .outBit(outBit),
    .outEmpty(outEmpty),
    .outBusy(outBusy),
    .outDone(outDone),
    .outError(outError)
  );
  always #5 inClock = ~inClock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_bit"}, outBit, 0);
    check({tag, "_empty"}, outEmpty, 1);
    check({tag, "_ready"}, outReady, 0);
    check({tag, "_busy"}, outBusy, 0);
    check({tag, "_done"}, outDone, 0);
    check({tag, "_error"}, outError, 0);
  endtask
  task automatic tick();
    if (inBitReq && !outEmpty) got.push_back(outBit);
    if (inValid && outReady) void'(host_q.pop_front());
    @(posedge inClock);
    #1;
    cyc++;
    if (outDone) begin
      done_cnt++;
      done_at = got.size();
      done_empty = outEmpty;
    end
    if (outError) err_seen = 1'b1;
    inStart = 1'b0;
    inValid = host_q.size() > 0 && (!rnd_valid || $urandom_range(0, 1) == 1);
    inData = host_q.size() > 0 ? host_q[0] : 4'h0;
    inBitReq = (cyc % period) == 0;
  endtask
  task automatic build_exp(input int len);
    int sfd = 'hA7;
    exp_bits.delete();
    for (int i = 0; i < 32; i++) exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(((sfd >> i) & 1) != 0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(((len >> i) & 1) != 0);
    foreach (nibs[k]) for (int i = 0; i < 4; i++) exp_bits.push_back(((int'(nibs[k]) >> i) & 1) != 0);
  endtask
  task automatic load_frame(input int len);
    nibs.delete();
    for (int i = 0; i < 2 * len; i++) nibs.push_back(4'($urandom_range(0, 15)));
    host_q = nibs;
    build_exp(len);
  endtask
  task automatic start_frame(input int len);
    got.delete();
    done_cnt = 0;
    done_at = -1;
    inStart = 1'b1;
    inLength = 7'(len);
    tick();
    err_seen = 1'b0;
  endtask
  task automatic run_until_done(input string tag, input int budget);
    int b = budget;
    while (done_cnt == 0 && b > 0) begin
      tick();
      b--;
    end
    check({tag, "_done_seen"}, done_cnt, 1);
  endtask
  task automatic run_until_bits(input string tag, input int n, input int budget);
    int b = budget;
    while (got.size() < n && b > 0) begin
      tick();
      b--;
    end
    check({tag, "_bits_reached"}, got.size(), n);
  endtask
  task automatic compare_stream(input string tag);
    int mis = -1;
    check({tag, "_nbits"}, got.size(), exp_bits.size());
    for (int i = 0; i < got.size() && i < exp_bits.size(); i++)
      if (mis < 0 && got[i] != exp_bits[i]) mis = i;
    check({tag, "_first_bad_bit"}, mis, -1);
  endtask
  initial begin
    #2 inReset = 1'b1;
    #1 check_reset("rst_hold");
    repeat (3) @(posedge inClock);
    #1 inReset = 1'b0;
    @(posedge inClock);
    #1 check_reset("rst_release");
    period = 1;
    rnd_valid = 1'b0;
    nibs = '{4'hC, 4'h3};
    host_q = nibs;
    build_exp(1);
    start_frame(1);
    check("start_busy", outBusy, 1);
    check("start_empty", outEmpty, 0);
    check("start_bit", outBit, 0);
    run_until_done("single", 500);
    compare_stream("single");
    check("single_done_at", done_at, 56);
    check("single_done_empty", done_empty, 1);
    check("single_err", err_seen, 0);
    repeat (5) tick();
    check("single_done_once", done_cnt, 1);
    check("single_idle", outBusy, 0);
    got.delete();
    inStart = 1'b1;
    inLength = 7'd0;
    tick();
    check("len0_err", outError, 1);
    check("len0_busy", outBusy, 0);
    check("len0_empty", outEmpty, 1);
    repeat (3) tick();
    check("len0_stay_idle", outBusy, 0);
    check("len0_no_bits", got.size(), 0);
    nibs.delete();
    repeat (4) nibs.push_back(4'($urandom_range(0, 15)));
    build_exp(2);
    host_q = nibs[0:1];
    start_frame(2);
    check("ur_err_cleared", outError, 0);
    run_until_bits("ur", 56, 500);
    check("ur_empty", outEmpty, 1);
    check("ur_error", outError, 1);
    check("ur_busy", outBusy, 1);
    repeat (10) tick();
    check("ur_stalled_bits", got.size(), 56);
    check("ur_stalled_empty", outEmpty, 1);
    host_q.push_back(nibs[2]);
    host_q.push_back(nibs[3]);
    run_until_done("ur", 500);
    compare_stream("ur");
    check("ur_done_at", done_at, 64);
    check("ur_error_sticky", outError, 1);
    load_frame(3);
    start_frame(3);
    run_until_bits("mid_start", 60, 500);
    inStart = 1'b1;
    inLength = 7'd0;
    tick();
    check("mid_start_busy", outBusy, 1);
    check("mid_start_err", outError, 0);
    run_until_done("mid_start", 500);
    compare_stream("mid_start");
    check("mid_start_no_err", err_seen, 0);
    load_frame(2);
    start_frame(2);
    run_until_bits("mid_rst", 45, 500);
    inReset = 1'b1;
    #1 check_reset("mid_rst");
    inBitReq = 1'b0;
    inValid = 1'b0;
    host_q.delete();
    repeat (2) @(posedge inClock);
    #1 check("mid_rst_no_done", outDone, 0);
    check("mid_rst_no_done_cnt", done_cnt, 0);
    inReset = 1'b0;
    @(posedge inClock);
    #1 check_reset("post_abort");
    period = 5;
    rnd_valid = 1'b1;
    nibs = '{4'hC, 4'h3};
    host_q = nibs;
    build_exp(1);
    start_frame(1);
    run_until_done("thr", 2000);
    compare_stream("thr");
    check("thr_done_at", done_at, 56);
    check("thr_err", err_seen, 0);
    for (int f = 0; f < 3; f++) begin
      int len = $urandom_range(1, 8);
      period = $urandom_range(1, 3);
      load_frame(len);
      start_frame(len);
      run_until_done("rnd", 3000);
      compare_stream("rnd");
      check("rnd_done_at", done_at, exp_bits.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
